// File: rtl/prng_periph.sv
// prng_periph: memory-mapped pseudo-random number peripheral for the picosoc bus.
// It has a byte-writable seed register, a control register (steps, mode) and a
// data register. Reading the data register stalls the bus through reg_dat_wait
// while the generator advances a programmable number of steps. The generator is
// either a Galois right-shift LFSR or a linear counter.
// Optional feature: define PRNG_READ_COUNT_EN to add reg_cnt_do, a 32-bit count
// of completed reads that is cleared by reset and by any seed write.
module prng_periph #(
    parameter int          WIDTH         = 32,
    parameter logic [31:0] SEED_RESET    = 32'hDEAD_BEEF,
    parameter logic [31:0] TAPS          = 32'h8020_0003,
    parameter logic [7:0]  STEPS_DEFAULT = 8'd1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH/8-1:0]   reg_seed_we,
    input  logic [WIDTH-1:0]     reg_seed_di,
    output logic [WIDTH-1:0]     reg_seed_do,
    input  logic                 reg_ctrl_we,
    input  logic [31:0]          reg_ctrl_di,
    output logic [31:0]          reg_ctrl_do,
    input  logic                 reg_dat_re,
    output logic [WIDTH-1:0]     reg_dat_do,
    output logic                 reg_dat_wait
`ifdef PRNG_READ_COUNT_EN
    ,
    output logic [31:0]          reg_cnt_do
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [WIDTH-1:0] SEED_W = SEED_RESET[WIDTH-1:0];
    localparam logic [WIDTH-1:0] TAPS_W = TAPS[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_seed;
    logic [WIDTH-1:0] r_state;
    logic [7:0]       r_steps;
    logic             r_mode;
    logic [1:0]       r_fsm;
    logic [7:0]       r_cnt;
    logic             r_run_mode;
    logic             r_reload_pend;
    logic             w_seed_wr;
    logic             w_wait;

    // One generator step: counter increments and wraps; LFSR shifts right with
    // Galois feedback, and an all-zero state is forced to 1 so it cannot lock up.
    function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] s,
                                                input logic             mode);
        logic [WIDTH-1:0] nxt;
        if (mode) begin
            nxt = s + ONE_W;
        end else if (s == '0) begin
            nxt = ONE_W;
        end else if (s[0]) begin
            nxt = (s >> 1) ^ TAPS_W;
        end else begin
            nxt = s >> 1;
        end
        return nxt;
    endfunction

    assign w_seed_wr = |reg_seed_we;

    // Seed register: each enabled byte lane takes the bus data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seed <= SEED_W;
        end else begin
            for (int b = 0; b < WIDTH/8; b++) begin
                if (reg_seed_we[b]) begin
                    r_seed[b*8 +: 8] <= reg_seed_di[b*8 +: 8];
                end
            end
        end
    end

    // Control register: steps and mode, read by the FSM only at read acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_steps <= STEPS_DEFAULT;
            r_mode  <= 1'b0;
        end else if (reg_ctrl_we) begin
            r_steps <= reg_ctrl_di[7:0];
            r_mode  <= reg_ctrl_di[8];
        end
    end

    // Read FSM, generator state and pending-reload flag. A seed written while a
    // read is in flight is only applied once the FSM is back in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm         <= S_IDLE;
            r_state       <= SEED_W;
            r_reload_pend <= 1'b0;
            r_cnt         <= 8'd0;
            r_run_mode    <= 1'b0;
        end else begin
            // A new seed write keeps the flag set even in the cycle it is consumed.
            r_reload_pend <= w_seed_wr | (r_reload_pend & (r_fsm != S_IDLE));
            case (r_fsm)
                S_IDLE: begin
                    if (r_reload_pend) begin
                        r_state <= r_seed;
                    end
                    if (reg_dat_re) begin
                        r_run_mode <= r_mode;
                        r_cnt      <= r_steps;
                        r_fsm      <= (r_steps == 8'd0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    r_state <= f_step(r_state, r_run_mode);
                    r_cnt   <= r_cnt - 8'd1;
                    if (r_cnt == 8'd1) begin
                        r_fsm <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_fsm <= S_IDLE;
                end
                default: begin
                    r_fsm <= S_IDLE;
                end
            endcase
        end
    end

    // Stall: follows the strobe in IDLE, held through RUN, released in DONE.
    always_comb begin
        w_wait = 1'b0;
        case (r_fsm)
            S_IDLE:  w_wait = reg_dat_re;
            S_RUN:   w_wait = 1'b1;
            default: w_wait = 1'b0;
        endcase
    end

`ifdef PRNG_READ_COUNT_EN
    logic [31:0] r_rd_cnt;

    // Completed-read counter: counts DONE cycles, cleared by any seed write.
    always_ff @(posedge clk) begin
        if (reset || w_seed_wr) begin
            r_rd_cnt <= 32'd0;
        end else if (r_fsm == S_DONE) begin
            r_rd_cnt <= r_rd_cnt + 32'd1;
        end
    end

    assign reg_cnt_do = r_rd_cnt;
`endif

    assign reg_seed_do  = r_seed;
    assign reg_ctrl_do  = {23'd0, r_mode, r_steps};
    assign reg_dat_do   = r_state;
    assign reg_dat_wait = w_wait;

endmodule

// File: tb/tb_prng_periph.sv
// Testbench for prng_periph: table of directed read transactions plus
// hand-written sequences for byte writes, reset mid-read and seed/ctrl writes
// during a read in flight.
module tb_prng_periph;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  reg_seed_we;
    logic [31:0] reg_seed_di;
    logic [31:0] reg_seed_do;
    logic        reg_ctrl_we;
    logic [31:0] reg_ctrl_di;
    logic [31:0] reg_ctrl_do;
    logic        reg_dat_re;
    logic [31:0] reg_dat_do;
    logic        reg_dat_wait;
`ifdef PRNG_READ_COUNT_EN
    logic [31:0] reg_cnt_do;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int exp_rc  = 0;

    always #5 clk = ~clk;

    prng_periph dut (
        .clk          (clk),
        .reset        (reset),
        .reg_seed_we  (reg_seed_we),
        .reg_seed_di  (reg_seed_di),
        .reg_seed_do  (reg_seed_do),
        .reg_ctrl_we  (reg_ctrl_we),
        .reg_ctrl_di  (reg_ctrl_di),
        .reg_ctrl_do  (reg_ctrl_do),
        .reg_dat_re   (reg_dat_re),
        .reg_dat_do   (reg_dat_do),
        .reg_dat_wait (reg_dat_wait)
`ifdef PRNG_READ_COUNT_EN
        ,
        .reg_cnt_do   (reg_cnt_do)
`endif
    );

    typedef struct {
        logic        mode;
        logic [7:0]  steps;
        logic        ld_seed;
        logic [31:0] seed;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_rc(input string name);
`ifdef PRNG_READ_COUNT_EN
        check(name, reg_cnt_do, exp_rc);
`endif
    endtask

    task automatic write_seed(input logic [3:0] we, input logic [31:0] di);
        reg_seed_we = we;
        reg_seed_di = di;
        tick();
        reg_seed_we = 4'd0;
        exp_rc = 0;
    endtask

    task automatic write_ctrl(input logic mode, input logic [7:0] steps);
        reg_ctrl_we = 1'b1;
        reg_ctrl_di = {23'd0, mode, steps};
        tick();
        reg_ctrl_we = 1'b0;
    endtask

    task automatic do_read(input string name, input logic [31:0] exp, input int lat);
        int n;
        reg_dat_re = 1'b1;
        #1;
        check({name, " wait_accept"}, {31'd0, reg_dat_wait}, 32'd1);
        n = 0;
        while (reg_dat_wait && n < 400) begin
            tick();
            n++;
        end
        check({name, " latency"}, n, lat);
        check({name, " data"}, reg_dat_do, exp);
        reg_dat_re = 1'b0;
        tick();
        exp_rc++;
    endtask

    initial begin
        int n;
        reset       = 1'b1;
        reg_seed_we = 4'd0;
        reg_seed_di = 32'd0;
        reg_ctrl_we = 1'b0;
        reg_ctrl_di = 32'd0;
        reg_dat_re  = 1'b0;

        vecs[0] = '{1'b0, 8'd1,   1'b1, 32'h0000_0001, 32'h8020_0003, 2};
        vecs[1] = '{1'b1, 8'd3,   1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 4};
        vecs[2] = '{1'b1, 8'd0,   1'b0, 32'h0000_0000, 32'h0000_0001, 1};
        vecs[3] = '{1'b0, 8'd1,   1'b1, 32'h0000_0000, 32'h0000_0001, 2};
        vecs[4] = '{1'b0, 8'd2,   1'b1, 32'h0000_0001, 32'hC030_0002, 3};
        vecs[5] = '{1'b0, 8'd1,   1'b1, 32'h0000_0002, 32'h0000_0001, 2};
        vecs[6] = '{1'b1, 8'd255, 1'b1, 32'h0000_0010, 32'h0000_010F, 256};
        vecs[7] = '{1'b0, 8'd1,   1'b0, 32'h0000_0000, 32'h8020_0084, 2};

        tick();
        tick();
        reset = 1'b0;
        exp_rc = 0;

        // Reset values
        check("rst seed", reg_seed_do, 32'hDEAD_BEEF);
        check("rst ctrl", reg_ctrl_do, 32'h0000_0001);
        check("rst data", reg_dat_do, 32'hDEAD_BEEF);
        check("rst wait", {31'd0, reg_dat_wait}, 32'd0);
        check_rc("rst rdcnt");

        // Byte-lane seed write, then reload in the following IDLE cycle
        write_seed(4'b0010, 32'h0000_1200);
        check("byte seed", reg_seed_do, 32'hDEAD_12EF);
        check("byte state_before_reload", reg_dat_do, 32'hDEAD_BEEF);
        tick();
        check("byte state_reloaded", reg_dat_do, 32'hDEAD_12EF);

        // Table of read transactions
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].ld_seed) write_seed(4'hF, vecs[i].seed);
            write_ctrl(vecs[i].mode, vecs[i].steps);
            do_read($sformatf("vec%0d", i), vecs[i].exp, vecs[i].lat);
            check_rc($sformatf("vec%0d rdcnt", i));
        end

        // Reset pulse in the middle of a long read, together with a seed write
        write_seed(4'hF, 32'h0000_0000);
        write_ctrl(1'b1, 8'd200);
        reg_dat_re = 1'b1;
        #1;
        repeat (50) tick();
        check("midrst wait_in_run", {31'd0, reg_dat_wait}, 32'd1);
        reg_seed_we = 4'hF;
        reg_seed_di = 32'h0000_0055;
        reset       = 1'b1;
        tick();
        reset       = 1'b0;
        reg_seed_we = 4'd0;
        reg_dat_re  = 1'b0;
        exp_rc      = 0;
        #1;
        check("midrst data", reg_dat_do, 32'hDEAD_BEEF);
        check("midrst wait", {31'd0, reg_dat_wait}, 32'd0);
        check("midrst seed", reg_seed_do, 32'hDEAD_BEEF);
        check("midrst ctrl", reg_ctrl_do, 32'h0000_0001);
        check_rc("midrst rdcnt");
        // A fresh default read proves the FSM is back in IDLE with default ctrl
        do_read("postrst", 32'hEF76_DF74, 2);

        // Seed and ctrl writes during a read in flight do not disturb it
        write_seed(4'hF, 32'h0000_0000);
        write_ctrl(1'b1, 8'd200);
        reg_dat_re = 1'b1;
        #1;
        n = 0;
        while (reg_dat_wait && n < 400) begin
            if (n == 50) begin
                reg_seed_we = 4'hF;
                reg_seed_di = 32'h0000_0055;
                reg_ctrl_we = 1'b1;
                reg_ctrl_di = {23'd0, 1'b1, 8'd1};
            end
            tick();
            if (n == 50) begin
                reg_seed_we = 4'd0;
                reg_ctrl_we = 1'b0;
                exp_rc = 0;
            end
            n++;
        end
        check("midwr latency", n, 201);
        check("midwr data", reg_dat_do, 32'h0000_00C8);
        check("midwr seed", reg_seed_do, 32'h0000_0055);
        reg_dat_re = 1'b0;
        tick();
        exp_rc++;
        check_rc("midwr rdcnt");
        // Next read (new ctrl: counter, 1 step) starts from the new seed
        do_read("afterwr", 32'h0000_0056, 2);
        check_rc("afterwr rdcnt");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
